rca_seq_ctrl: RTL and testbench

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_seq_pkg.sv | 23 ++
 rtl/ripple_carry_adder.sv | 28 ++
 rtl/rca_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rca_seq_pkg : shared types and constants for the sequential ripple-carry adder
// Rev 1.0
// ----------------------------------------------------------------------------
package rca_seq_pkg;

  localparam int SLICE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    DONE = ST_DONE
  } state_e;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ripple_carry_adder : WIDTH-bit ripple-carry adder built from full-adder cells
// Rev 1.0
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rca_seq_ctrl : two-requester add controller time-sharing one 4-bit slice,
// LS nibble first. Optional rsp_ovf output enabled by macro RCA_SEQ_OVF_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_cout,
`ifdef RCA_SEQ_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   rsp_id
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_e            state_q, state_d;
  req_id_t           prio_q, prio_d;
  req_id_t           id_q, id_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  req_id_t           rsp_id_q, rsp_id_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [W-1:0]       next_full;
  req_id_t            gnt_id;
  logic               idle;
  logic               last_slice;

  ripple_carry_adder #(
    .WIDTH (SLICE_W)
  ) u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Completed low nibbles shift down from the top so the final slice lands in the MSBs.
  if (NIBBLES > 1) begin : g_acc
    logic [W-SLICE_W-1:0] acc_q, acc_d;

    always_comb begin
      acc_d = acc_q;
      if (state_q == ADD) acc_d = next_full[W-1:SLICE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
    end

    assign next_full = {slice_sum, acc_q};
  end else begin : g_no_acc
    assign next_full = slice_sum;
  end

  assign idle       = (state_q == IDLE);
  assign last_slice = (cnt_q == LAST_CNT);

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_id = prio_q;
    if (req0_valid && !req1_valid)      gnt_id = 1'b0;
    else if (req1_valid && !req0_valid) gnt_id = 1'b1;
  end

  assign req0_ready = idle && req0_valid && (gnt_id == 1'b0);
  assign req1_ready = idle && req1_valid && (gnt_id == 1'b1);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d   = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = ADD;
          prio_d  = ~gnt_id;
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_a   : req0_a;
          b_d     = gnt_id ? req1_b   : req0_b;
          carry_d = gnt_id ? req1_cin : req0_cin;
          cnt_d   = '0;
        end
      end
      ADD: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          state_d    = DONE;
          rsp_sum_d  = next_full;
          rsp_cout_d = slice_cout;
          rsp_id_d   = id_q;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef RCA_SEQ_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;
  logic slice_c_msb;

  // Carry into the slice MSB recovered from its sum bit, not from a second adder.
  assign slice_c_msb = a_q[SLICE_W-1] ^ b_q[SLICE_W-1] ^ slice_sum[SLICE_W-1];

  always_comb begin
    rsp_ovf_d = rsp_ovf_q;
    if (state_q == ADD && last_slice) rsp_ovf_d = slice_c_msb ^ slice_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_ovf_q <= 1'b0;
    else        rsp_ovf_q <= rsp_ovf_d;
  end

  assign rsp_ovf = rsp_ovf_q;
`endif

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rca_seq_ctrl : directed-vector scoreboard bench for rca_seq_ctrl (NIBBLES=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rca_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;
`ifdef RCA_SEQ_OVF_EN
  logic         rsp_ovf;
`endif

  always #5 clk = ~clk;

  rca_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
`ifdef RCA_SEQ_OVF_EN
    .rsp_ovf    (rsp_ovf),
`endif
    .rsp_id     (rsp_id)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: accept bookkeeping, latency, DONE stability and response scoreboard.
  logic         prev_valid = 1'b0, prev_hs = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0, prev_id = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_edge = cyc + 1;
      if (rsp_valid && !prev_valid) check("latency", cyc - acc_edge, NIB);
      if (rsp_valid) begin
        check("ready0_low_in_done", req0_ready, 0);
        check("ready1_low_in_done", req1_ready, 0);
      end
      if (rsp_valid && prev_valid && !prev_hs) begin
        check("hold_sum", rsp_sum, prev_sum);
        check("hold_cout", rsp_cout, prev_cout);
        check("hold_id", rsp_id, prev_id);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          check("rsp_sum", rsp_sum, e.sum);
          check("rsp_cout", rsp_cout, e.cout);
          check("rsp_id", rsp_id, e.id);
`ifdef RCA_SEQ_OVF_EN
          check("rsp_ovf", rsp_ovf, e.ovf);
`endif
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_sum   = rsp_sum;
      prev_cout  = rsp_cout;
      prev_id    = rsp_id;
    end
  end

  task automatic push_exp(input logic id, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.id = id; e.ovf = eo;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    push_exp(id, es, ec, eo);
    @(posedge clk); #1;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("accept_timeout");
    @(posedge clk); #1;
    // Scramble request inputs after accept; the operation in flight must ignore them.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_cin = ~cin;
    req1_a = ~a; req1_b = ~b; req1_cin = ~cin;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while ((exp_q.size() != 0 || rsp_valid) && n < 200);
    if (n >= 200) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
  endtask

  initial begin
    int k, n;
    logic seen;

    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
`ifdef RCA_SEQ_OVF_EN
    check("rst_rsp_ovf", rsp_ovf, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    push_exp(1'b0, 16'h1210, 1'b0, 1'b0);
    push_exp(1'b1, 16'h0009, 1'b0, 1'b0);
    push_exp(1'b0, 16'h1210, 1'b0, 1'b0);
    push_exp(1'b1, 16'h0009, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_a = 16'h0BB0; req0_b = 16'h0660; req0_cin = 1'b0;
    req1_a = 16'h0005; req1_b = 16'h0003; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) begin
        check("grant_order", req1_ready, k % 2);
        check("single_grant", req0_ready & req1_ready, 0);
        k++;
      end
    end
    if (k < 4) fail_now("alternate_timeout");
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    issue(1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
    wait_drain();
    issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_drain();
    issue(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: hold rsp_ready low 5 cycles in DONE with both valids asserted.
    rsp_ready = 1'b0;
    issue(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("rsp_valid_timeout");
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_exit", rsp_valid, 0);
    wait_drain();

    // Asynchronous reset during the second ADD cycle aborts the operation.
    issue(1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_sum", rsp_sum, 0);
    check("arst_rsp_cout", rsp_cout, 0);
    check("arst_rsp_id", rsp_id, 0);
`ifdef RCA_SEQ_OVF_EN
    check("arst_rsp_ovf", rsp_ovf, 0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", seen, 0);

    issue(1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
